score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Scoring stage directly upstream of the 7-segment display driver.
- Consumes one-cycle judgment pulses from the arrow-timing judge.
- Maintains the running score, the current combo, the max combo and a timed combo-display request.
- Drives the display's score, comboCount and combo_enable inputs from registers.

Parameters:
- SCORE_MAX, 9999, saturation ceiling for score; must fit the 4-digit display.
- COMBO_MAX, 99, saturation ceiling for combo and max_combo.
- COMBO_STEP, 10, combo milestone interval; also the multiplier step.
- MULT_MAX, 4, maximum score multiplier.
- PTS_GOOD, 1, base points for a good hit.
- PTS_PERFECT, 2, base points for a perfect hit.
- SHOW_TICKS, 500, number of tick_en strobes that combo_enable stays high after a milestone.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- tick_en  in  1  one-cycle timebase strobe (1 kHz); used only by the show timer.
- game_active  in  1  level from the game FSM; high while play is running.
- clear  in  1  one-cycle pulse; starts a new game.
- hit_good  in  1  one-cycle pulse; good hit judged.
- hit_perfect  in  1  one-cycle pulse; perfect hit judged.
- miss  in  1  one-cycle pulse; arrow missed.
- score  out  14  running score, binary, 0..SCORE_MAX.
- comboCount  out  7  current combo, 0..COMBO_MAX.
- max_combo  out  7  highest combo reached this game.
- combo_enable  out  1  high while the display should show the combo.
- state_o  out  2  FSM state: 0 IDLE, 1 PLAY, 2 HOLD.

Behaviour:
- Reset values (rst high at a clk edge):
  - score=0, comboCount=0, max_combo=0, combo_enable=0.
  - Show timer=0, state IDLE.
  - rst overrides every other input, including mid-show and mid-update.
- FSM:
  - IDLE -> PLAY when game_active=1.
  - PLAY -> HOLD when game_active=0.
  - HOLD -> PLAY when game_active=1; score and combo are retained.
  - clear in any state -> IDLE next cycle, with the same zeroing as reset.
  - clear has priority over game_active and over judgments in the same cycle.
- Judgments are acted on only in PLAY; they are ignored in IDLE, in HOLD, and in the cycle clear is high.
- Simultaneous pulses in one cycle: priority miss > hit_perfect > hit_good; exactly one event is processed.
- Multiplier:
  - mult = min(1 + comboCount/COMBO_STEP, MULT_MAX).
  - comboCount is the value before the current event; integer division.
- Hit (good or perfect):
  - score_next = min(score + base*mult, SCORE_MAX); base is PTS_GOOD or PTS_PERFECT.
  - Compute the sum at 15 bits before clamping.
  - comboCount_next = min(comboCount+1, COMBO_MAX).
  - max_combo_next = max(max_combo, comboCount_next).
- Miss: comboCount_next=0; score and max_combo unchanged; combo_enable forced to 0 and show timer cleared in the same cycle.
- Latency: all outputs are registered; they change on the edge after the judgment cycle (1-cycle latency). No combinational input-to-output path.
- Milestone:
  - A hit whose comboCount_next is a nonzero multiple of COMBO_STEP, and differs from the current comboCount, loads the show timer with SHOW_TICKS and sets combo_enable=1.
  - Holding at COMBO_MAX never retriggers a milestone.
  - A new milestone while showing reloads the timer to SHOW_TICKS.
- Show timer:
  - Decrements on each tick_en while combo_enable=1.
  - At the tick_en that takes it from 1 to 0, combo_enable drops on that same edge.
  - The timer keeps counting in HOLD; it stops only on clear, miss or rst.
  - A tick_en in the same cycle as a milestone load is ignored; the load wins.

Test Plan:
- rst, game_active=1, 3 hit_good pulses -> score=3, comboCount=3, max_combo=3, combo_enable=0, each output updated exactly 1 cycle after its pulse.
- 10 hit_perfect from zero -> score=20, comboCount=10, combo_enable=1; next hit_perfect gives +4 (score=24). After SHOW_TICKS=500 tick_en strobes with no events, combo_enable=0.
- Combo 12, then miss together with hit_perfect in one cycle -> comboCount=0, score unchanged, max_combo=12, combo_enable=0 immediately.
- Score 9995 and combo 40 (mult 4), hit_perfect -> score=9999 (saturates); 120 further hits -> comboCount holds at 99 and no milestone retrigger at 99.
- game_active 1->0 mid-game, then hit pulses -> state_o=2 and no score change; game_active->1 -> state_o=1 with score/combo retained. clear while PLAY with a simultaneous hit -> all outputs 0, state_o=0.
- rst asserted while combo_enable=1 with the timer at 250 -> all outputs 0 next edge; subsequent tick_en strobes cause no change.

Source files
------------

// File: rtl/score_keeper.sv
`default_nettype none
// score_keeper: turns judge pulses into score, combo, max combo and a timed
// combo-display request for the 7-segment driver. All outputs are registered.
module score_keeper #(
  parameter int SCORE_MAX   = 9999,
  parameter int COMBO_MAX   = 99,
  parameter int COMBO_STEP  = 10,
  parameter int MULT_MAX    = 4,
  parameter int PTS_GOOD    = 1,
  parameter int PTS_PERFECT = 2,
  parameter int SHOW_TICKS  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        game_active,
  input  logic        clear,
  input  logic        hit_good,
  input  logic        hit_perfect,
  input  logic        miss,
  output logic [13:0] score,
  output logic [6:0]  comboCount,
  output logic [6:0]  max_combo,
  output logic        combo_enable,
  output logic [1:0]  state_o
);

  localparam int SCORE_W = 14;
  localparam int COMBO_W = 7;
  localparam int ADD_W   = 15;
  localparam int TIMER_W = $clog2(SHOW_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [SCORE_W-1:0]   score_next;
  logic [COMBO_W-1:0]   combo_next, max_next;
  logic                 enable_next;
  logic [TIMER_W-1:0]   timer, timer_next;

  logic [COMBO_W-1:0]   tier, combo_inc;
  logic [ADD_W-1:0]     mult, base, sum;
  logic                 hit_any, milestone;

  always_comb begin
    state_next  = state;
    score_next  = score;
    combo_next  = comboCount;
    max_next    = max_combo;
    enable_next = combo_enable;
    timer_next  = timer;

    tier      = comboCount / COMBO_W'(COMBO_STEP);
    mult      = (tier >= COMBO_W'(MULT_MAX - 1)) ? ADD_W'(MULT_MAX) : ADD_W'(tier) + ADD_W'(1);
    hit_any   = hit_good | hit_perfect;
    base      = hit_perfect ? ADD_W'(PTS_PERFECT) : ADD_W'(PTS_GOOD);
    // One bit of headroom so the clamp sees the true sum.
    sum       = {1'b0, score} + base * mult;
    combo_inc = (comboCount >= COMBO_W'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX)
                                                    : comboCount + COMBO_W'(1);
    milestone = (combo_inc != comboCount) && (combo_inc != '0) &&
                ((combo_inc % COMBO_W'(COMBO_STEP)) == '0);

    case (state)
      IDLE:    if (game_active)  state_next = PLAY;
      PLAY:    if (!game_active) state_next = HOLD;
      HOLD:    if (game_active)  state_next = PLAY;
      default: state_next = IDLE;
    endcase

    // Show timer runs in every state; only miss, clear or rst stop it.
    if (tick_en && combo_enable) begin
      timer_next = timer - TIMER_W'(1);
      if (timer == TIMER_W'(1)) enable_next = 1'b0;
    end

    if (state == PLAY) begin
      if (miss) begin
        combo_next  = '0;
        enable_next = 1'b0;
        timer_next  = '0;
      end else if (hit_any) begin
        score_next = (sum > ADD_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
        combo_next = combo_inc;
        if (combo_inc > max_combo) max_next = combo_inc;
        if (milestone) begin
          timer_next  = TIMER_W'(SHOW_TICKS);
          enable_next = 1'b1;
        end
      end
    end

    if (clear) begin
      state_next  = IDLE;
      score_next  = '0;
      combo_next  = '0;
      max_next    = '0;
      enable_next = 1'b0;
      timer_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      score        <= '0;
      comboCount   <= '0;
      max_combo    <= '0;
      combo_enable <= 1'b0;
      timer        <= '0;
    end else begin
      state        <= state_next;
      score        <= score_next;
      comboCount   <= combo_next;
      max_combo    <= max_next;
      combo_enable <= enable_next;
      timer        <= timer_next;
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// Directed self-checking bench for score_keeper; inputs change on the falling edge.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst, tick_en, game_active, clear, hit_good, hit_perfect, miss;
  logic [13:0] score;
  logic [6:0]  comboCount, max_combo;
  logic        combo_enable;
  logic [1:0]  state_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .game_active(game_active),
    .clear(clear), .hit_good(hit_good), .hit_perfect(hit_perfect), .miss(miss),
    .score(score), .comboCount(comboCount), .max_combo(max_combo),
    .combo_enable(combo_enable), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int c, input int m,
                         input int e, input int st);
    chk({tag, "_score"}, 32'(score), 32'(s));
    chk({tag, "_combo"}, 32'(comboCount), 32'(c));
    chk({tag, "_max"},   32'(max_combo), 32'(m));
    chk({tag, "_en"},    32'(combo_enable), 32'(e));
    chk({tag, "_state"}, 32'(state_o), 32'(st));
  endtask

  // Holds the chosen judgment inputs high for n consecutive cycles.
  task automatic hits(input logic g, input logic p, input logic m, input int n);
    hit_good = g; hit_perfect = p; miss = m;
    repeat (n) @(negedge clk);
    hit_good = 0; hit_perfect = 0; miss = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);  // back to PLAY while game_active is high
  endtask

  initial begin
    rst = 1; tick_en = 0; game_active = 0; clear = 0;
    hit_good = 0; hit_perfect = 0; miss = 0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 0;
    game_active = 1;
    @(negedge clk);
    chk("idle_to_play", 32'(state_o), 32'd1);

    // Three good hits, each visible exactly one edge later.
    for (int i = 1; i <= 3; i++) begin
      hit_good = 1;
      #1 chk("no_comb_path", 32'(score), 32'(i - 1));
      @(negedge clk);
      hit_good = 0;
      chk("good_score", 32'(score), 32'(i));
      chk("good_combo", 32'(comboCount), 32'(i));
    end
    chk_all("three_good", 3, 3, 3, 0, 1);

    // Clear with a simultaneous hit wins.
    clear = 1; hit_good = 1;
    @(negedge clk);
    clear = 0; hit_good = 0;
    chk_all("clear_hit", 0, 0, 0, 0, 0);
    @(negedge clk);

    // Ten perfect hits reach the first milestone; the eleventh earns double.
    hits(0, 1, 0, 10);
    chk_all("perfect10", 20, 10, 10, 1, 1);
    hits(0, 1, 0, 1);
    chk_all("perfect11", 24, 11, 11, 1, 1);
    tick_en = 1;
    repeat (499) @(negedge clk);
    chk("show_499", 32'(combo_enable), 32'd1);
    @(negedge clk);
    tick_en = 0;
    chk("show_500", 32'(combo_enable), 32'd0);

    // Combo 12 showing, then miss with hit_perfect.
    do_clear();
    hits(1, 0, 0, 12);
    chk_all("combo12", 14, 12, 12, 1, 1);
    hits(0, 1, 1, 1);
    chk_all("miss_prio", 14, 0, 12, 0, 1);
    tick_en = 1;
    repeat (3) @(negedge clk);
    tick_en = 0;
    chk("miss_stays_off", 32'(combo_enable), 32'd0);

    // Build score 9800 in 49 runs of 40 perfects (200 each), then 195 more at combo 40.
    do_clear();
    for (int r = 0; r < 49; r++) begin
      hits(0, 1, 0, 40);
      hits(0, 0, 1, 1);
    end
    chk_all("build", 9800, 0, 40, 0, 1);
    hits(1, 0, 0, 5);
    hits(0, 1, 0, 35);
    chk_all("score9995", 9995, 40, 40, 1, 1);
    hits(0, 1, 0, 1);
    chk_all("saturate", 9999, 41, 41, 1, 1);
    hits(1, 0, 0, 120);
    chk_all("combo_cap", 9999, 99, 99, 1, 1);
    // Holding at 99 while ticking: any retrigger would keep the display lit.
    tick_en = 1;
    hits(1, 0, 0, 499);
    chk("cap_499", 32'(combo_enable), 32'd1);
    hits(1, 0, 0, 1);
    tick_en = 0;
    chk_all("no_retrigger", 9999, 99, 99, 0, 1);

    // HOLD ignores judgments and keeps values.
    do_clear();
    hits(1, 0, 0, 3);
    game_active = 0;
    @(negedge clk);
    chk("hold_state", 32'(state_o), 32'd2);
    hits(1, 1, 0, 3);
    chk_all("hold_ignore", 3, 3, 3, 0, 2);
    game_active = 1;
    @(negedge clk);
    chk_all("resume", 3, 3, 3, 0, 1);
    hits(1, 0, 0, 1);
    chk_all("resume_hit", 4, 4, 4, 0, 1);
    clear = 1; hit_perfect = 1;
    @(negedge clk);
    clear = 0; hit_perfect = 0;
    chk_all("clear_play", 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset mid-show with the timer at 250.
    hits(0, 1, 0, 10);
    tick_en = 1;
    repeat (250) @(negedge clk);
    chk("mid_show", 32'(combo_enable), 32'd1);
    rst = 1;
    @(negedge clk);
    chk_all("rst_mid", 0, 0, 0, 0, 0);
    rst = 0; game_active = 0;
    repeat (300) @(negedge clk);
    tick_en = 0;
    chk_all("rst_after_ticks", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
